dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the datapath's load/store interface.
- Accepts one load or store request at a time through a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte/half/word access with sign or zero extension selected by funct3, then returns the result through a valid/ready response channel.
- Sits between the datapath's data-memory port and a 128-word on-chip RAM. Two monitored words are exposed for the FPGA display path.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with valid/ready request and response channels.
//   Accepts one load/store at a time, waits WAIT_CYC cycles, then accesses a
//   2^(ADDR_W-2)-word RAM with byte/half/word lanes and sign/zero extension.
//   Optional build macro: DMEM_WPROT_EN (refuse stores below WPROT_LIMIT).
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_funct3 : request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                      : response channel
//   mon0_data, mon1_data : live contents of words MON0_IDX / MON1_IDX
module dmem_responder #(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 32,
    parameter int                WAIT_CYC    = 2,
    parameter int                MON0_IDX    = 11,
    parameter int                MON1_IDX    = 12,
    parameter logic [ADDR_W-1:0] WPROT_LIMIT = 9'd64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] mon0_data,
    output logic [DATA_W-1:0] mon1_data
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [ADDR_W-3:0] M0 = MON0_IDX[ADDR_W-3:0];
    localparam logic [ADDR_W-3:0] M1 = MON1_IDX[ADDR_W-3:0];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              l_we, c_we;
    logic [ADDR_W-1:0] l_addr, c_addr;
    logic [DATA_W-1:0] l_wdata, c_wdata;
    logic [2:0]        l_f3, c_f3;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-3:0] idx;
    logic [1:0]        lane;
    logic [DATA_W-1:0] word, bsel, hsel, rdata, wd, bm;
    logic [3:0]        be;
    logic              accept, commit, bad_f3, mis, prot, err, ram_we;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept    = req_ready && req_valid;
    // With zero wait states the request is accepted and executed on the same
    // edge, so the access must see the live request rather than the latch.
    assign commit    = (accept && WAIT_CYC == 0) || (state == WAIT && cnt == 4'd0);

    assign c_we    = req_ready ? req_we     : l_we;
    assign c_addr  = req_ready ? req_addr   : l_addr;
    assign c_wdata = req_ready ? req_wdata  : l_wdata;
    assign c_f3    = req_ready ? req_funct3 : l_f3;

    assign idx  = c_addr[ADDR_W-1:2];
    assign lane = c_addr[1:0];
    assign word = mem[idx];
    assign bsel = word >> {lane, 3'b000};
    assign hsel = word >> {c_addr[1], 4'b0000};

    // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
    assign bad_f3 = c_we ? (c_f3[2] || c_f3[1:0] == 2'b11)
                         : (c_f3[1:0] == 2'b11 || c_f3 == 3'b110);
    assign mis    = (c_f3[1:0] == 2'b01 && c_addr[0]) ||
                    (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00);
`ifdef DMEM_WPROT_EN
    assign prot = c_we && (c_addr < WPROT_LIMIT);
`else
    logic unused_wprot;
    assign unused_wprot = ^WPROT_LIMIT;
    assign prot = 1'b0;
`endif
    assign err = bad_f3 || mis || prot;

    // funct3[2] selects zero extension for byte/half loads.
    assign rdata = (c_we || err)          ? '0 :
                   c_f3[1:0] == 2'b10     ? word :
                   c_f3[1:0] == 2'b01     ? {{16{hsel[15] & ~c_f3[2]}}, hsel[15:0]} :
                                            {{24{bsel[7] & ~c_f3[2]}}, bsel[7:0]};

    assign be = c_f3[1:0] == 2'b10 ? 4'hF :
                c_f3[1:0] == 2'b01 ? (c_addr[1] ? 4'b1100 : 4'b0011) :
                                     4'b0001 << lane;
    assign wd = c_f3[1:0] == 2'b10 ? c_wdata :
                c_f3[1:0] == 2'b01 ? {2{c_wdata[15:0]}} :
                                     {4{c_wdata[7:0]}};
    assign bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    // The RAM is not reset, so gate the write with reset to drop a store whose
    // commit edge coincides with reset being held.
    assign ram_we = commit && reset && c_we && !err;

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[idx] <= (word & ~bm) | (wd & bm);
    end

    assign mon0_data = mem[M0];
    assign mon1_data = mem[M1];

    // cnt holds the wait cycles still to spend; WAIT exits once it reaches 0,
    // so the response appears WAIT_CYC+1 edges after acceptance.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                state_n = (WAIT_CYC == 0) ? RESP : WAIT;
                cnt_n   = 4'(WAIT_CYC);
            end
            WAIT: if (cnt == 4'd0) state_n = RESP;
                  else             cnt_n   = cnt - 4'd1;
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            l_we      <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= '0;
            l_f3      <= 3'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                l_we    <= req_we;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_f3    <= req_funct3;
            end
            if (commit) begin
                rsp_rdata <= rdata;
                rsp_err   <= err;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder using directed load/store vectors.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mon0_data, mon1_data;

    typedef struct {
        logic [31:0] d;
        logic        e;
        bit          cd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   nrsp = 0;

    dmem_responder dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mon0_data(mon0_data), .mon1_data(mon1_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Monitor: pops one expectation per response handshake.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk($sformatf("rsp%0d_err", nrsp), {31'd0, rsp_err}, {31'd0, x.e});
                if (x.cd) chk($sformatf("rsp%0d_data", nrsp), rsp_rdata, x.d);
            end
            nrsp++;
        end
    end

    task automatic issue(input logic we, input logic [8:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic [31:0] er, input logic ee,
                         input bit cd, input bit push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        if (push) sb.push_back('{er, ee, cd});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic xfer(input logic we, input logic [8:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic [31:0] er, input logic ee);
        issue(we, a, d, f, er, ee, 1'b1, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        xfer(1, 9'h2C, 32'hDEADBEEF, 3'b010, 32'h0, 0);
        xfer(0, 9'h2C, 32'h0,        3'b010, 32'hDEADBEEF, 0);
        chk("mon0_sw", mon0_data, 32'hDEADBEEF);
        xfer(1, 9'h2D, 32'h00000080, 3'b000, 32'h0, 0);
        xfer(0, 9'h2D, 32'h0, 3'b000, 32'hFFFFFF80, 0);
        xfer(0, 9'h2D, 32'h0, 3'b100, 32'h00000080, 0);
        xfer(0, 9'h2C, 32'h0, 3'b010, 32'hDEAD80EF, 0);
        xfer(0, 9'h2E, 32'h0, 3'b001, 32'hFFFFDEAD, 0);
        xfer(0, 9'h2E, 32'h0, 3'b101, 32'h0000DEAD, 0);
        chk("mon0_sb", mon0_data, 32'hDEAD80EF);

        xfer(1, 9'h30, 32'h11112222, 3'b010, 32'h0, 0);
        xfer(0, 9'h31, 32'h0, 3'b001, 32'h0, 1);
        xfer(1, 9'h32, 32'h99999999, 3'b010, 32'h0, 1);
        chk("mon1_mis_sw", mon1_data, 32'h11112222);
        xfer(0, 9'h30, 32'h0, 3'b011, 32'h0, 1);
        xfer(0, 9'h30, 32'h0, 3'b110, 32'h0, 1);
        xfer(1, 9'h30, 32'h55555555, 3'b100, 32'h0, 1);
        xfer(1, 9'h30, 32'h55555555, 3'b101, 32'h0, 1);
        chk("mon1_bad_f3", mon1_data, 32'h11112222);
        xfer(1, 9'h32, 32'h0000ABCD, 3'b001, 32'h0, 0);
        xfer(0, 9'h30, 32'h0, 3'b010, 32'hABCD2222, 0);
        chk("mon1_sh", mon1_data, 32'hABCD2222);

        // Latency and stall: accepted at edge N, rsp_valid from N+3, held while stalled.
        rsp_ready = 1'b0;
        issue(0, 9'h2C, 32'h0, 3'b010, 32'hDEAD80EF, 0, 1'b1, 1'b1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 9'h2C;
        req_wdata  = 32'h0;
        req_funct3 = 3'b010;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_valid_%0d", k), {31'd0, rsp_valid}, {31'd0, k >= 3});
            chk($sformatf("lat_ready_%0d", k), {31'd0, req_ready}, 32'd0);
            if (k >= 3) begin
                chk($sformatf("stall_data_%0d", k), rsp_rdata, 32'hDEAD80EF);
                chk($sformatf("stall_err_%0d", k), {31'd0, rsp_err}, 32'd0);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        xfer(0, 9'h2C, 32'h0, 3'b010, 32'hDEAD80EF, 0);

        // Reset during WAIT drops the pending store.
        issue(1, 9'h30, 32'h12345678, 3'b010, 32'h0, 0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("wrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("wrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("wrst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("wrst_mon1", mon1_data, 32'hABCD2222);
        xfer(0, 9'h30, 32'h0, 3'b010, 32'hABCD2222, 0);

`ifdef DMEM_WPROT_EN
        xfer(1, 9'h10, 32'hCAFEF00D, 3'b010, 32'h0, 1);
        issue(0, 9'h10, 32'h0, 3'b010, 32'h0, 0, 1'b0, 1'b1);
        drain();
`else
        xfer(1, 9'h10, 32'hCAFEF00D, 3'b010, 32'h0, 0);
        xfer(0, 9'h10, 32'h0, 3'b010, 32'hCAFEF00D, 0);
`endif
        xfer(0, 9'h13, 32'h0, 3'b000, 32'hFFFFFFCA, 0);
        xfer(0, 9'h12, 32'h0, 3'b101, 32'h0000CAFE, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
